multicycle_sequencer: RTL and testbench

// - Multicycle control FSM for the Feather core: fetch, decode, execute, memory and writeback.
// - Replaces single-cycle control. Holds the instruction register (IR) and the NZCV flags.

---
 rtl/feather_pkg.sv | 46 ++++
 rtl/cond_eval.sv | 40 ++++
 rtl/multicycle_sequencer.sv | 164 ++++++++++++++++
 tb/tb_multicycle_sequencer.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/feather_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// feather_pkg: shared Feather core types and IR field positions (rev 1.0)
// ---------------------------------------------------------------------------
package feather_pkg;

  localparam int COND_MSB = 31;
  localparam int TYPE_MSB = 27;
  localparam int SL_BIT   = 20;

  typedef enum logic [1:0] {
    IT_DP     = 2'b00,
    IT_MEM    = 2'b01,
    IT_BRANCH = 2'b10,
    IT_UNDEF  = 2'b11
  } instr_type_e;

  typedef enum logic [3:0] {
    COND_EQ = 4'h0,
    COND_NE = 4'h1,
    COND_CS = 4'h2,
    COND_CC = 4'h3,
    COND_MI = 4'h4,
    COND_PL = 4'h5,
    COND_VS = 4'h6,
    COND_VC = 4'h7,
    COND_HI = 4'h8,
    COND_LS = 4'h9,
    COND_GE = 4'hA,
    COND_LT = 4'hB,
    COND_GT = 4'hC,
    COND_LE = 4'hD,
    COND_AL = 4'hE,
    COND_NV = 4'hF
  } cond_e;

  typedef enum logic [2:0] {
    ST_FETCH     = 3'd0,
    ST_DECODE    = 3'd1,
    ST_EXECUTE   = 3'd2,
    ST_MEM       = 3'd3,
    ST_WRITEBACK = 3'd4
  } seq_state_e;

endpackage
`default_nettype wire

// File: rtl/cond_eval.sv
`default_nettype none
// ---------------------------------------------------------------------------
// cond_eval: combinational ARM-style condition check on {N,Z,C,V} (rev 1.0)
// ---------------------------------------------------------------------------
module cond_eval
  import feather_pkg::*;
(
  input  logic [3:0] cond_i,
  input  logic [3:0] nzcv_i,
  output logic       pass_o
);

  logic n, z, c, v;
  assign {n, z, c, v} = nzcv_i;

  always_comb begin
    pass_o = 1'b0;
    unique case (cond_e'(cond_i))
      COND_EQ: pass_o = z;
      COND_NE: pass_o = ~z;
      COND_CS: pass_o = c;
      COND_CC: pass_o = ~c;
      COND_MI: pass_o = n;
      COND_PL: pass_o = ~n;
      COND_VS: pass_o = v;
      COND_VC: pass_o = ~v;
      COND_HI: pass_o = c & ~z;
      COND_LS: pass_o = ~c | z;
      COND_GE: pass_o = (n == v);
      COND_LT: pass_o = (n != v);
      COND_GT: pass_o = ~z & (n == v);
      COND_LE: pass_o = z | (n != v);
      COND_AL: pass_o = 1'b1;
      COND_NV: pass_o = 1'b0;
      default: pass_o = 1'b0;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/multicycle_sequencer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// multicycle_sequencer: Feather fetch/decode/execute/mem/writeback FSM (rev 1.0)
// ---------------------------------------------------------------------------
module multicycle_sequencer
  import feather_pkg::*;
#(
  parameter logic [3:0]  NZCV_RESET = 4'b0000,
  parameter int unsigned WAIT_LIMIT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] instr_rdata_i,
  input  logic        instr_ready_i,
  output logic        instr_req_o,
  output logic [31:0] instr_o,
  output logic        pc_write_enable_o,
  output logic        pc_src_o,
  input  logic [3:0]  nzcv_i,
  output logic [3:0]  nzcv_o,
  output logic        data_req_o,
  output logic        data_we_o,
  input  logic        data_ready_i,
  output logic        reg_file_write_enable_o,
  output logic        reg_write_src_o,
  output logic        undef_o,
  output logic        bus_error_o
);

  localparam int unsigned     CNT_W   = $clog2(WAIT_LIMIT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(WAIT_LIMIT);

  seq_state_e       state_q, state_d;
  logic [31:0]      ir_q, ir_d;
  logic [3:0]       nzcv_q, nzcv_d;
  logic [CNT_W-1:0] wait_q, wait_d;
  logic             cond_pass_q, cond_pass_d;

  logic        cond_pass;
  logic        wait_expired;
  instr_type_e itype;
  logic        sl_bit;

  logic instr_req, pc_we, pc_src, data_req, data_we, reg_we, reg_src, undef, bus_err;

  assign itype        = instr_type_e'(ir_q[TYPE_MSB -: 2]);
  assign sl_bit       = ir_q[SL_BIT];
  assign wait_expired = (wait_q == CNT_MAX);

  cond_eval u_cond_eval (
    .cond_i (ir_q[COND_MSB -: 4]),
    .nzcv_i (nzcv_q),
    .pass_o (cond_pass)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_FETCH;
      ir_q        <= '0;
      nzcv_q      <= NZCV_RESET;
      wait_q      <= '0;
      cond_pass_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      ir_q        <= ir_d;
      nzcv_q      <= nzcv_d;
      wait_q      <= wait_d;
      cond_pass_q <= cond_pass_d;
    end
  end

  // The wait counter defaults to zero, so every entry into FETCH or MEM starts clean.
  always_comb begin
    state_d     = state_q;
    ir_d        = ir_q;
    nzcv_d      = nzcv_q;
    wait_d      = '0;
    cond_pass_d = cond_pass_q;
    instr_req   = 1'b0;
    pc_we       = 1'b0;
    pc_src      = 1'b0;
    data_req    = 1'b0;
    data_we     = 1'b0;
    reg_we      = 1'b0;
    reg_src     = 1'b0;
    undef       = 1'b0;
    bus_err     = 1'b0;

    unique case (state_q)
      ST_FETCH: begin
        instr_req = 1'b1;
        if (instr_ready_i) begin
          ir_d    = instr_rdata_i;
          pc_we   = 1'b1;
          state_d = ST_DECODE;
        end else if (wait_expired) begin
          bus_err = 1'b1;
        end else begin
          wait_d = wait_q + CNT_W'(1);
        end
      end

      ST_DECODE: begin
        cond_pass_d = cond_pass;
        state_d     = cond_pass ? ST_EXECUTE : ST_FETCH;
      end

      ST_EXECUTE: begin
        state_d = ST_FETCH;
        if (cond_pass_q) begin
          unique case (itype)
            IT_DP: begin
              reg_we = 1'b1;
              if (sl_bit) nzcv_d = nzcv_i;
            end
            IT_BRANCH: begin
              pc_we  = 1'b1;
              pc_src = 1'b1;
            end
            IT_MEM:   state_d = ST_MEM;
            IT_UNDEF: undef   = 1'b1;
            default:  state_d = ST_FETCH;
          endcase
        end
      end

      ST_MEM: begin
        data_req = 1'b1;
        data_we  = ~sl_bit;
        if (data_ready_i) begin
          state_d = sl_bit ? ST_WRITEBACK : ST_FETCH;
        end else if (wait_expired) begin
          bus_err = 1'b1;
          state_d = ST_FETCH;
        end else begin
          wait_d = wait_q + CNT_W'(1);
        end
      end

      ST_WRITEBACK: begin
        reg_we  = 1'b1;
        reg_src = 1'b1;
        state_d = ST_FETCH;
      end

      default: state_d = ST_FETCH;
    endcase
  end

  // Strobes are gated by rst directly so an in-flight request drops without waiting for a clock.
  assign instr_req_o             = instr_req & ~rst;
  assign pc_write_enable_o       = pc_we     & ~rst;
  assign pc_src_o                = pc_src    & ~rst;
  assign data_req_o              = data_req  & ~rst;
  assign data_we_o               = data_we   & ~rst;
  assign reg_file_write_enable_o = reg_we    & ~rst;
  assign reg_write_src_o         = reg_src   & ~rst;
  assign undef_o                 = undef     & ~rst;
  assign bus_error_o             = bus_err   & ~rst;
  assign instr_o                 = ir_q;
  assign nzcv_o                  = nzcv_q;

endmodule
`default_nettype wire

// File: tb/tb_multicycle_sequencer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_multicycle_sequencer: directed scoreboard bench for the Feather sequencer (rev 1.0)
// ---------------------------------------------------------------------------
module tb_multicycle_sequencer;

  localparam logic [3:0] NZCV_RST = 4'b0010;
  localparam int         WLIM     = 4;

  localparam int S_IREQ  = 8;
  localparam int S_PCWE  = 7;
  localparam int S_PCSRC = 6;
  localparam int S_DREQ  = 5;
  localparam int S_DWE   = 4;
  localparam int S_RWE   = 3;
  localparam int S_RSRC  = 2;
  localparam int S_UNDEF = 1;
  localparam int S_BERR  = 0;

  logic        clk;
  logic        rst;
  logic [31:0] instr_rdata_i;
  logic        instr_ready_i;
  logic        instr_req_o;
  logic [31:0] instr_o;
  logic        pc_write_enable_o;
  logic        pc_src_o;
  logic [3:0]  nzcv_i;
  logic [3:0]  nzcv_o;
  logic        data_req_o;
  logic        data_we_o;
  logic        data_ready_i;
  logic        reg_file_write_enable_o;
  logic        reg_write_src_o;
  logic        undef_o;
  logic        bus_error_o;

  multicycle_sequencer #(
    .NZCV_RESET (NZCV_RST),
    .WAIT_LIMIT (WLIM)
  ) dut (
    .clk                     (clk),
    .rst                     (rst),
    .instr_rdata_i           (instr_rdata_i),
    .instr_ready_i           (instr_ready_i),
    .instr_req_o             (instr_req_o),
    .instr_o                 (instr_o),
    .pc_write_enable_o       (pc_write_enable_o),
    .pc_src_o                (pc_src_o),
    .nzcv_i                  (nzcv_i),
    .nzcv_o                  (nzcv_o),
    .data_req_o              (data_req_o),
    .data_we_o               (data_we_o),
    .data_ready_i            (data_ready_i),
    .reg_file_write_enable_o (reg_file_write_enable_o),
    .reg_write_src_o         (reg_write_src_o),
    .undef_o                 (undef_o),
    .bus_error_o             (bus_error_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [8:0] act_s;
  assign act_s = {instr_req_o, pc_write_enable_o, pc_src_o, data_req_o, data_we_o,
                  reg_file_write_enable_o, reg_write_src_o, undef_o, bus_error_o};

  typedef struct packed {
    logic       irdy;
    logic       drdy;
    logic [8:0] s;
    logic [3:0] nz;
  } cyc_t;

  cyc_t       exp_q[$];
  logic [3:0] m_nzcv;
  int         checks   = 0;
  int         failures = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic bit cond_ok(input logic [3:0] cc, input logic [3:0] f);
    bit n, z, c, v;
    {n, z, c, v} = f;
    case (cc)
      4'h0: return z;
      4'h1: return !z;
      4'h2: return c;
      4'h3: return !c;
      4'h4: return n;
      4'h5: return !n;
      4'h6: return v;
      4'h7: return !v;
      4'h8: return c && !z;
      4'h9: return !c || z;
      4'hA: return n == v;
      4'hB: return n != v;
      4'hC: return !z && (n == v);
      4'hD: return z || (n != v);
      4'hE: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  // Builds the expected per-cycle trace of one instruction, including watchdog aborts.
  task automatic model_instr(input logic [31:0] ins, input logic [3:0] alu, input int fw, input int mw);
    cyc_t c;
    int   cnt;
    bit   done;
    cnt  = 0;
    done = 0;
    while (!done) begin
      c = '0; c.nz = m_nzcv; c.s[S_IREQ] = 1'b1;
      if (fw > 0) begin
        fw--;
        if (cnt == WLIM) begin c.s[S_BERR] = 1'b1; cnt = 0; end
        else cnt++;
      end else begin
        c.irdy = 1'b1; c.s[S_PCWE] = 1'b1; done = 1;
      end
      exp_q.push_back(c);
    end
    c = '0; c.nz = m_nzcv;
    exp_q.push_back(c);
    if (!cond_ok(ins[31:28], m_nzcv)) return;
    c = '0; c.nz = m_nzcv;
    case (ins[27:26])
      2'b00: c.s[S_RWE] = 1'b1;
      2'b10: begin c.s[S_PCWE] = 1'b1; c.s[S_PCSRC] = 1'b1; end
      2'b11: c.s[S_UNDEF] = 1'b1;
      default: ;
    endcase
    exp_q.push_back(c);
    if (ins[27:26] == 2'b00 && ins[20]) m_nzcv = alu;
    if (ins[27:26] != 2'b01) return;
    cnt  = 0;
    done = 0;
    while (!done) begin
      c = '0; c.nz = m_nzcv; c.s[S_DREQ] = 1'b1; c.s[S_DWE] = !ins[20];
      if (mw > 0) begin
        mw--;
        if (cnt == WLIM) begin
          c.s[S_BERR] = 1'b1;
          exp_q.push_back(c);
          return;
        end
        cnt++;
      end else begin
        c.drdy = 1'b1; done = 1;
      end
      exp_q.push_back(c);
    end
    if (ins[20]) begin
      c = '0; c.nz = m_nzcv; c.s[S_RWE] = 1'b1; c.s[S_RSRC] = 1'b1;
      exp_q.push_back(c);
    end
  endtask

  task automatic run(input string name, input logic [31:0] ins, input logic [3:0] alu,
                     input int fw, input int mw);
    cyc_t c;
    int   i;
    nzcv_i = alu;
    model_instr(ins, alu, fw, mw);
    i = 0;
    while (exp_q.size() > 0) begin
      c = exp_q.pop_front();
      instr_ready_i = c.irdy;
      data_ready_i  = c.drdy;
      instr_rdata_i = c.irdy ? ins : 32'hDEAD_BEEF;
      #1;
      chk($sformatf("%s.c%0d.strobes", name, i), {23'b0, act_s}, {23'b0, c.s});
      chk($sformatf("%s.c%0d.nzcv", name, i), {28'b0, nzcv_o}, {28'b0, c.nz});
      @(posedge clk); #1;
      i++;
    end
    instr_ready_i = 1'b0;
    data_ready_i  = 1'b0;
    chk($sformatf("%s.ir", name), instr_o, ins);
  endtask

  initial begin
    rst           = 1'b1;
    instr_rdata_i = '0;
    instr_ready_i = 1'b0;
    data_ready_i  = 1'b0;
    nzcv_i        = '0;
    m_nzcv        = NZCV_RST;
    repeat (2) @(posedge clk);
    #1;
    chk("reset.strobes", {23'b0, act_s}, 32'h0);
    chk("reset.nzcv", {28'b0, nzcv_o}, {28'b0, NZCV_RST});
    chk("reset.ir", instr_o, 32'h0);
    rst = 1'b0;

    run("eq_squash",   32'h0011_2003, 4'b1111, 0, 0);
    run("add_al_s",    32'hE011_2003, 4'b0100, 0, 0);
    run("ne_squash",   32'h1011_2003, 4'b1111, 0, 0);
    run("eq_pass_s",   32'h0011_2003, 4'b1001, 0, 0);
    run("dp_no_s",     32'hE001_2003, 4'b0000, 0, 0);
    run("ge_branch",   32'hAA00_0010, 4'b0000, 0, 0);
    run("lt_squash",   32'hBA00_0010, 4'b0000, 0, 0);
    run("ldr_wait3",   32'hE591_2000, 4'b0000, 0, 3);
    run("str_zero",    32'hE581_2000, 4'b0000, 0, 0);
    run("str_at_lim",  32'hE581_2000, 4'b0000, 0, WLIM);
    run("ldr_abort",   32'hE591_2000, 4'b0000, 0, WLIM + 1);
    run("undef",       32'hEC00_0000, 4'b0000, 0, 0);
    run("nv_squash",   32'hF011_2003, 4'b0000, 0, 0);
    run("fetch_abort", 32'hE011_2003, 4'b0110, WLIM + 2, 0);
    run("fetch_lim",   32'hE011_2003, 4'b1111, WLIM, 0);

    // Reset while a store is waiting in MEM.
    instr_rdata_i = 32'hE581_2000;
    instr_ready_i = 1'b1;
    @(posedge clk); #1;
    instr_ready_i = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("rst_mid.mem_strobes", {23'b0, act_s}, 32'h0000_0030);
    rst = 1'b1;
    #1;
    chk("rst_mid.strobes", {23'b0, act_s}, 32'h0);
    chk("rst_mid.nzcv", {28'b0, nzcv_o}, {28'b0, NZCV_RST});
    chk("rst_mid.ir", instr_o, 32'h0);
    @(posedge clk); #1;
    rst    = 1'b0;
    m_nzcv = NZCV_RST;
    #1;
    chk("rst_mid.fetch", {23'b0, act_s}, 32'h0000_0100);
    run("post_rst", 32'hE011_2003, 4'b1000, 0, 0);
    #1;
    chk("final.fetch", {23'b0, act_s}, 32'h0000_0100);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
